l1_pmem_arbiter: RTL and testbench

//  Memory-side responder for the two L1 caches. Accepts line-sized pmem requests from
//  the icache (read only) and the dcache (read or write-back). Serialises them onto the

---
 rtl/l1_pmem_arbiter_pkg.sv | 23 ++
 rtl/l1_pmem_arbiter_control.sv | 64 ++++++
 rtl/l1_pmem_arbiter.sv | 90 +++++++++
 tb/tb_l1_pmem_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l1_pmem_arbiter_pkg.sv
// Shared types for the L1-to-L2 pmem arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package l1_pmem_arbiter_pkg;

  localparam int ADDR_WIDTH = 16;
  localparam int LINE_WIDTH = 128;

  typedef logic [ADDR_WIDTH-1:0] lc3b_word;
  typedef logic [LINE_WIDTH-1:0] pmem_L1_bus;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SERVE_I = 2'd1,
    ST_SERVE_D = 2'd2
  } arb_state_e;

  typedef enum logic {
    REQ_ICACHE = 1'b0,
    REQ_DCACHE = 1'b1
  } requester_e;

endpackage

// File: rtl/l1_pmem_arbiter_control.sv
// Arbiter FSM: round-robin grant between icache and dcache, one L2 transaction at a time.
// Latency: grant on the IDLE sampling edge, SERVE state visible the following cycle.
// Backpressure: stays in SERVE until l2_resp; IDLE always lasts at least one cycle.
module l1_pmem_arbiter_control
  import l1_pmem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_req,
  input  logic       i_d_req,
  input  logic       i_l2_resp,
  output arb_state_e o_state,
  output logic       o_grant_i,
  output logic       o_grant_d
);

  arb_state_e r_state;
  arb_state_e w_next_state;
  requester_e r_last_grant;
  logic       w_grant_i;
  logic       w_grant_d;

  // Next-state and grant decision; simultaneous requests go to whoever did not win last.
  always_comb begin
    w_next_state = r_state;
    w_grant_i    = 1'b0;
    w_grant_d    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_req && i_d_req) begin
          if (r_last_grant == REQ_ICACHE) w_grant_d = 1'b1;
          else                            w_grant_i = 1'b1;
        end else if (i_d_req) begin
          w_grant_d = 1'b1;
        end else if (i_req) begin
          w_grant_i = 1'b1;
        end
        if (w_grant_d)      w_next_state = ST_SERVE_D;
        else if (w_grant_i) w_next_state = ST_SERVE_I;
      end
      ST_SERVE_I, ST_SERVE_D: begin
        if (i_l2_resp) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State register and round-robin history; reset makes the dcache win the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_last_grant <= REQ_ICACHE;
    end else begin
      r_state <= w_next_state;
      if (w_grant_i)      r_last_grant <= REQ_ICACHE;
      else if (w_grant_d) r_last_grant <= REQ_DCACHE;
    end
  end

  assign o_state   = r_state;
  assign o_grant_i = w_grant_i;
  assign o_grant_d = w_grant_d;

endmodule

// File: rtl/l1_pmem_arbiter.sv
// Serialises icache/dcache line requests onto the single L2 port and routes the response back.
// Latency: 1 cycle request-to-strobe, then L2 latency; resp is combinational from l2_resp.
// Backpressure: L1 requests are held by the caches until their resp; one transaction in flight.
module l1_pmem_arbiter
  import l1_pmem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = l1_pmem_arbiter_pkg::ADDR_WIDTH,
  parameter int LINE_WIDTH = l1_pmem_arbiter_pkg::LINE_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_pmem_read,
  input  logic [ADDR_WIDTH-1:0] i_pmem_address,
  output logic [LINE_WIDTH-1:0] i_pmem_rdata,
  output logic                  i_pmem_resp,
  input  logic                  d_pmem_read,
  input  logic                  d_pmem_write,
  input  logic [ADDR_WIDTH-1:0] d_pmem_address,
  input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
  output logic [LINE_WIDTH-1:0] d_pmem_rdata,
  output logic                  d_pmem_resp,
  output logic                  l2_read,
  output logic                  l2_write,
  output logic [ADDR_WIDTH-1:0] l2_address,
  output logic [LINE_WIDTH-1:0] l2_wdata,
  input  logic [LINE_WIDTH-1:0] l2_rdata,
  input  logic                  l2_resp
);

  arb_state_e            w_state;
  logic                  w_grant_i;
  logic                  w_grant_d;
  logic                  w_d_req;
  logic                  w_serve_i;
  logic                  w_serve_d;
  logic                  w_busy;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LINE_WIDTH-1:0] r_wdata;
  logic                  r_write;

  assign w_d_req = d_pmem_read | d_pmem_write;

  l1_pmem_arbiter_control u_control (
    .clk       (clk),
    .reset     (reset),
    .i_req     (i_pmem_read),
    .i_d_req   (w_d_req),
    .i_l2_resp (l2_resp),
    .o_state   (w_state),
    .o_grant_i (w_grant_i),
    .o_grant_d (w_grant_d)
  );

  // Request register: snapshot of the winner's address/data/op taken on the grant edge,
  // so L1 inputs wandering during SERVE have no effect. A read+write dcache request is a write.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_write <= 1'b0;
    end else if (w_grant_d) begin
      r_addr  <= d_pmem_address;
      r_wdata <= d_pmem_wdata;
      r_write <= d_pmem_write;
    end else if (w_grant_i) begin
      r_addr  <= i_pmem_address;
      r_wdata <= '0;
      r_write <= 1'b0;
    end
  end

  // Reset gates everything so an abandoned L2 response never reaches an L1 cache.
  assign w_serve_i = (w_state == ST_SERVE_I) && !reset;
  assign w_serve_d = (w_state == ST_SERVE_D) && !reset;
  assign w_busy    = w_serve_i | w_serve_d;

  assign l2_read    = w_busy & ~r_write;
  assign l2_write   = w_busy & r_write;
  assign l2_address = w_busy ? r_addr  : '0;
  assign l2_wdata   = w_busy ? r_wdata : '0;

  assign i_pmem_resp  = w_serve_i & l2_resp;
  assign d_pmem_resp  = w_serve_d & l2_resp;
  assign i_pmem_rdata = w_serve_i ? l2_rdata : '0;
  assign d_pmem_rdata = w_serve_d ? l2_rdata : '0;

  a_d_rd_wr_exclusive: assert property (@(posedge clk) disable iff (reset)
    !(d_pmem_read && d_pmem_write));

endmodule

// File: tb/tb_l1_pmem_arbiter.sv
// Randomised bench for l1_pmem_arbiter with a transaction-level reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_l1_pmem_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic         i_pmem_read;
  logic [15:0]  i_pmem_address;
  logic [127:0] i_pmem_rdata;
  logic         i_pmem_resp;
  logic         d_pmem_read;
  logic         d_pmem_write;
  logic [15:0]  d_pmem_address;
  logic [127:0] d_pmem_wdata;
  logic [127:0] d_pmem_rdata;
  logic         d_pmem_resp;
  logic         l2_read;
  logic         l2_write;
  logic [15:0]  l2_address;
  logic [127:0] l2_wdata;
  logic [127:0] l2_rdata;
  logic         l2_resp;

  always #5 clk = ~clk;

  l1_pmem_arbiter dut (
    .clk            (clk),
    .reset          (reset),
    .i_pmem_read    (i_pmem_read),
    .i_pmem_address (i_pmem_address),
    .i_pmem_rdata   (i_pmem_rdata),
    .i_pmem_resp    (i_pmem_resp),
    .d_pmem_read    (d_pmem_read),
    .d_pmem_write   (d_pmem_write),
    .d_pmem_address (d_pmem_address),
    .d_pmem_wdata   (d_pmem_wdata),
    .d_pmem_rdata   (d_pmem_rdata),
    .d_pmem_resp    (d_pmem_resp),
    .l2_read        (l2_read),
    .l2_write       (l2_write),
    .l2_address     (l2_address),
    .l2_wdata       (l2_wdata),
    .l2_rdata       (l2_rdata),
    .l2_resp        (l2_resp)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: the one transaction currently owned by L2, if any (owner 0=icache, 1=dcache).
  bit         m_valid = 1'b0;
  bit         m_owner = 1'b0;
  bit         m_write = 1'b0;
  bit [15:0]  m_addr  = '0;
  bit [127:0] m_wdata = '0;
  bit         m_last  = 1'b0;

  // Agent bookkeeping.
  bit i_seen_resp = 1'b0;
  bit d_seen_resp = 1'b0;
  bit l2_active   = 1'b0;
  int l2_wait     = 0;
  bit resp_log[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  // Advance the model by one rising edge from the inputs the DUT also samples.
  task automatic model_update();
    bit i_req, d_req, win_d;
    i_req = i_pmem_read;
    d_req = d_pmem_read | d_pmem_write;
    if (reset) begin
      m_valid = 1'b0;
      m_last  = 1'b0;
    end else if (m_valid) begin
      if (l2_resp) m_valid = 1'b0;
    end else if (i_req || d_req) begin
      win_d   = (i_req && d_req) ? (m_last == 1'b0) : d_req;
      m_valid = 1'b1;
      m_owner = win_d;
      m_last  = win_d;
      m_write = win_d && d_pmem_write;
      m_addr  = win_d ? d_pmem_address : i_pmem_address;
      m_wdata = d_pmem_wdata;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  // Per-cycle comparison of every output against the model.
  task automatic check_outputs();
    bit busy, own_i, own_d;
    busy  = m_valid && !reset;
    own_i = busy && (m_owner == 1'b0);
    own_d = busy && (m_owner == 1'b1);
    chk("l2_read",  {127'd0, l2_read},  {127'd0, busy && !m_write});
    chk("l2_write", {127'd0, l2_write}, {127'd0, busy && m_write});
    chk("l2_address", {112'd0, l2_address}, busy ? {112'd0, m_addr} : 128'd0);
    if (!busy)          chk("l2_wdata_idle", l2_wdata, 128'd0);
    else if (m_write)   chk("l2_wdata", l2_wdata, m_wdata);
    chk("i_resp",  {127'd0, i_pmem_resp}, {127'd0, own_i && l2_resp});
    chk("d_resp",  {127'd0, d_pmem_resp}, {127'd0, own_d && l2_resp});
    chk("i_rdata", i_pmem_rdata, own_i ? l2_rdata : 128'd0);
    chk("d_rdata", d_pmem_rdata, own_d ? l2_rdata : 128'd0);
    i_seen_resp = i_pmem_resp;
    d_seen_resp = d_pmem_resp;
    if (i_pmem_resp) resp_log.push_back(1'b0);
    if (d_pmem_resp) resp_log.push_back(1'b1);
  endtask

  // L1 caches (hold until resp, then drop for a cycle) and an L2 with 0..3 cycles of latency.
  task automatic drive_agents(input bit gen_new, input bit always_req);
    bit wr;
    if (i_seen_resp) begin
      i_pmem_read = 1'b0;
    end else if (!i_pmem_read) begin
      if (always_req || (gen_new && $urandom_range(0, 2) == 0)) begin
        i_pmem_read    = 1'b1;
        i_pmem_address = 16'($urandom);
      end
    end else if ($urandom_range(0, 3) == 0) begin
      i_pmem_address = 16'($urandom);
    end

    if (d_seen_resp) begin
      d_pmem_read  = 1'b0;
      d_pmem_write = 1'b0;
    end else if (!(d_pmem_read || d_pmem_write)) begin
      if (always_req || (gen_new && $urandom_range(0, 2) == 0)) begin
        wr             = 1'($urandom_range(0, 1));
        d_pmem_read    = !wr;
        d_pmem_write   = wr;
        d_pmem_address = 16'($urandom);
        d_pmem_wdata   = {$urandom, $urandom, $urandom, $urandom};
      end
    end else if ($urandom_range(0, 3) == 0) begin
      d_pmem_address = 16'($urandom);
      d_pmem_wdata   = {$urandom, $urandom, $urandom, $urandom};
    end

    l2_rdata = {$urandom, $urandom, $urandom, $urandom};
    if (!(l2_read || l2_write)) begin
      l2_resp   = 1'b0;
      l2_active = 1'b0;
    end else begin
      if (!l2_active) begin
        l2_active = 1'b1;
        l2_wait   = $urandom_range(0, 3);
      end
      if (l2_wait == 0) begin
        l2_resp = 1'b1;
      end else begin
        l2_resp = 1'b0;
        l2_wait--;
      end
    end
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    i_pmem_read  = 1'b0;
    d_pmem_read  = 1'b0;
    d_pmem_write = 1'b0;
    l2_resp      = 1'b0;
    i_seen_resp  = 1'b0;
    d_seen_resp  = 1'b0;
    l2_active    = 1'b0;
    #1 check_outputs();
    cycle();
    #1 check_outputs();
    cycle();
    reset = 1'b0;
    resp_log.delete();
  endtask

  task automatic run_until_log(input int n, input bit always_req, input string name);
    int k;
    k = 0;
    while (resp_log.size() < n && k < 100) begin
      drive_agents(1'b0, always_req);
      #1 check_outputs();
      cycle();
      k++;
    end
    chk({name, "_count"}, 128'(resp_log.size()), 128'(n));
  endtask

  localparam logic [127:0] LINE_A5 = {16{8'hA5}};
  localparam logic [127:0] WLINE   = 128'h0123456789ABCDEF0123456789ABCDEF;

  initial begin
    reset          = 1'b1;
    i_pmem_read    = 1'b0;
    i_pmem_address = '0;
    d_pmem_read    = 1'b0;
    d_pmem_write   = 1'b0;
    d_pmem_address = '0;
    d_pmem_wdata   = '0;
    l2_rdata       = '0;
    l2_resp        = 1'b0;
    @(negedge clk);
    do_reset();

    // Lone icache read, L2 answers on the fourth serve cycle.
    i_pmem_read    = 1'b1;
    i_pmem_address = 16'h1230;
    #1 check_outputs();
    chk("t1_idle_read", {127'd0, l2_read}, 128'd0);
    cycle();
    for (int c = 1; c <= 4; c++) begin
      l2_resp  = (c == 4);
      l2_rdata = LINE_A5;
      #1 check_outputs();
      chk("t1_l2_read", {127'd0, l2_read}, 128'd1);
      chk("t1_addr", {112'd0, l2_address}, 128'h1230);
      if (c == 4) begin
        chk("t1_i_resp", {127'd0, i_pmem_resp}, 128'd1);
        chk("t1_i_rdata", i_pmem_rdata, LINE_A5);
        chk("t1_d_resp", {127'd0, d_pmem_resp}, 128'd0);
      end
      cycle();
    end
    i_pmem_read = 1'b0;
    l2_resp     = 1'b0;
    #1 check_outputs();
    chk("t1_after", {127'd0, l2_read}, 128'd0);
    cycle();

    // Simultaneous reads after reset: dcache first.
    do_reset();
    i_pmem_read    = 1'b1;
    i_pmem_address = 16'h0100;
    d_pmem_read    = 1'b1;
    d_pmem_address = 16'h0200;
    run_until_log(2, 1'b0, "t2");
    if (resp_log.size() == 2) begin
      chk("t2_first",  {127'd0, resp_log[0]}, 128'd1);
      chk("t2_second", {127'd0, resp_log[1]}, 128'd0);
    end

    // Write-back then fill, with an address change during the write.
    do_reset();
    d_pmem_write   = 1'b1;
    d_pmem_address = 16'h4440;
    d_pmem_wdata   = WLINE;
    #1 check_outputs();
    cycle();
    d_pmem_address = 16'hFFFF;
    d_pmem_wdata   = '0;
    #1 check_outputs();
    chk("t3_write", {127'd0, l2_write}, 128'd1);
    chk("t3_addr",  {112'd0, l2_address}, 128'h4440);
    chk("t3_wdata", l2_wdata, WLINE);
    cycle();
    l2_resp = 1'b1;
    #1 check_outputs();
    chk("t3_held_addr", {112'd0, l2_address}, 128'h4440);
    chk("t3_d_resp", {127'd0, d_pmem_resp}, 128'd1);
    cycle();
    l2_resp        = 1'b0;
    d_pmem_write   = 1'b0;
    d_pmem_read    = 1'b1;
    d_pmem_address = 16'h8880;
    #1 check_outputs();
    chk("t3_gap", {126'd0, l2_read, l2_write}, 128'd0);
    cycle();
    #1 check_outputs();
    chk("t3_fill_read", {127'd0, l2_read}, 128'd1);
    chk("t3_fill_addr", {112'd0, l2_address}, 128'h8880);
    cycle();

    // Continuous requests from both: D,I,D,I,D,I.
    do_reset();
    run_until_log(6, 1'b1, "t4");
    if (resp_log.size() == 6)
      for (int k = 0; k < 6; k++)
        chk("t4_order", {127'd0, resp_log[k]}, {127'd0, (k % 2 == 0)});

    // Reset while the icache waits on L2.
    do_reset();
    i_pmem_read    = 1'b1;
    i_pmem_address = 16'h2468;
    #1 check_outputs();
    cycle();
    #1 check_outputs();
    chk("t6_serving", {127'd0, l2_read}, 128'd1);
    cycle();
    reset   = 1'b1;
    l2_resp = 1'b1;
    #1 check_outputs();
    chk("t6_no_resp", {127'd0, i_pmem_resp}, 128'd0);
    cycle();
    reset   = 1'b0;
    l2_resp = 1'b0;
    #1 check_outputs();
    chk("t6_idle", {126'd0, l2_read, i_pmem_resp}, 128'd0);
    chk("t6_addr", {112'd0, l2_address}, 128'd0);
    cycle();

    // Random traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      drive_agents(1'b1, 1'b0);
      reset = ($urandom_range(0, 199) == 0);
      if (reset) l2_resp = 1'($urandom_range(0, 1));
      #1 check_outputs();
      cycle();
    end
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
